// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART report/echo blocks.
//   - ASCII codes used when building text for the UART TX FIFO.
//   - State encoding for the hex reporter FSM.
//   - idx_width(): counter width for a message of n characters, at least 1 bit.
package uart_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CHAR = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CHAR = ST_CHAR,
    GAP  = ST_GAP
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/hex_to_ascii.sv
// hex_to_ascii: combinational 4-bit nibble to 8-bit ASCII hex digit.
// Parameters:
//   UPPERCASE - 1: A-F map to 0x41-0x46; 0: a-f map to 0x61-0x66
// Ports:
//   nibble - input  [3:0] value 0-15
//   ascii  - output [7:0] ASCII character for the nibble
module hex_to_ascii
  import uart_pkg::*;
#(
  parameter int UPPERCASE = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  localparam bit UC = (UPPERCASE != 32'sd0);

  // Digits 0-9 offset from '0', letters offset from 'A' or 'a'.
  always_comb begin
    ascii = ASCII_0;
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nibble};
    end else if (UC) begin
      ascii = ASCII_UA + {4'h0, nibble} - 8'd10;
    end else begin
      ascii = ASCII_LA + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_hex_reporter.sv
// uart_hex_reporter: latches a binary value on start and writes it as ASCII hex
// text (MS nibble first, optional CR LF) into the UART TX FIFO, one character
// per write, honouring tx_full.
// Parameters:
//   DATA_W    - width of reported value, multiple of 4 (NDIG = DATA_W/4 digits)
//   UPPERCASE - 1: uppercase A-F, 0: lowercase a-f
//   SEND_CRLF - 1: append 0x0D 0x0A after the digits
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   start    - report request, sampled only when idle
//   value    - value to report, latched on accepted start
//   tx_full  - UART TX FIFO full flag
//   wr_uart  - TX FIFO write strobe, one cycle per character
//   w_data   - ASCII character, valid while wr_uart=1
//   busy     - high from accepted start until message complete
//   done     - one-cycle pulse after the last character is written
module uart_hex_reporter
  import uart_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int UPPERCASE = 1,
  parameter int SEND_CRLF = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              done
);

  localparam bit CRLF_EN = (SEND_CRLF != 32'sd0);
  localparam int NDIG    = DATA_W / 4;
  localparam int N       = NDIG + (CRLF_EN ? 2 : 0);
  localparam int IDX_W   = idx_width(N);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  // Only meaningful when CR/LF is enabled; then NDIG <= N-1 always fits.
  localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(NDIG);

  state_t            state_r;
  logic [IDX_W-1:0]  index_r;
  logic [DATA_W-1:0] value_r;
  logic [3:0]        nibble_s;
  logic [7:0]        hex_s;
  logic [7:0]        char_s;

  // The latched value is shifted left after each character, so the
  // current digit is always the top nibble.
  assign nibble_s = value_r[DATA_W-1 -: 4];

  hex_to_ascii #(
    .UPPERCASE(UPPERCASE)
  ) u_hex_to_ascii (
    .nibble(nibble_s),
    .ascii (hex_s)
  );

  // Character for the current index: hex digit, then CR, then LF.
  always_comb begin
    char_s = hex_s;
    if (!CRLF_EN) begin
      char_s = hex_s;
    end else if (index_r < CR_IDX) begin
      char_s = hex_s;
    end else if (index_r == CR_IDX) begin
      char_s = ASCII_CR;
    end else begin
      char_s = ASCII_LF;
    end
  end

  // Report FSM. GAP follows every write so tx_full (updated one cycle after a
  // write) is re-sampled before the next character is offered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      index_r <= {IDX_W{1'b0}};
      value_r <= {DATA_W{1'b0}};
      wr_uart <= 1'b0;
      w_data  <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wr_uart <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            value_r <= value;
            index_r <= {IDX_W{1'b0}};
            busy    <= 1'b1;
            state_r <= CHAR;
          end else begin
            state_r <= IDLE;
          end
        end
        CHAR: begin
          done <= 1'b0;
          if (!tx_full) begin
            wr_uart <= 1'b1;
            w_data  <= char_s;
            state_r <= GAP;
          end else begin
            wr_uart <= 1'b0;
            state_r <= CHAR;
          end
        end
        GAP: begin
          wr_uart <= 1'b0;
          if (index_r == LAST_IDX) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= IDLE;
          end else begin
            index_r <= index_r + 1'b1;
            value_r <= value_r << 3'd4;
            done    <= 1'b0;
            state_r <= CHAR;
          end
        end
        default: begin
          wr_uart <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_reporter.sv
// tb_uart_hex_reporter: self-checking bench for uart_hex_reporter.
// Main instance uses defaults (16 bit, uppercase, CR LF); a second instance
// uses DATA_W=8, lowercase, no CR LF. Expected character streams come from a
// table of hand-written constants and from an arithmetic reference model.
module tb_uart_hex_reporter;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [15:0] value;
    logic [47:0] chars;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] value;
  logic        tx_force;
  logic        use_fifo;
  logic        drain_all;
  wire         tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;
  logic        done;

  logic        start2;
  logic [7:0]  value2;
  logic        wr2;
  logic [7:0]  wd2;
  logic        busy2;
  logic        done2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_hex_reporter dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .value  (value),
    .tx_full(tx_full),
    .wr_uart(wr_uart),
    .w_data (w_data),
    .busy   (busy),
    .done   (done)
  );

  uart_hex_reporter #(.DATA_W(8), .UPPERCASE(0), .SEND_CRLF(0)) dut2 (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start2),
    .value  (value2),
    .tx_full(1'b0),
    .wr_uart(wr2),
    .w_data (wd2),
    .busy   (busy2),
    .done   (done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_q(input string name, input bq_t got, input bq_t exp);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) check(name, got[i], exp[i]);
  endtask

  // Reference: message text computed directly from the value with arithmetic.
  function automatic bq_t ref_msg(input int v, input int ndig, input bit uc, input bit crlf);
    bq_t q;
    int d;
    for (int i = ndig - 1; i >= 0; i--) begin
      d = (v / (1 << (4 * i))) % 16;
      if (d < 10) q.push_back(8'(48 + d));
      else q.push_back(8'((uc ? 65 : 97) + d - 10));
    end
    if (crlf) begin
      q.push_back(8'd13);
      q.push_back(8'd10);
    end
    return q;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitors
  bq_t  cap_q;
  int   wcyc_q[$];
  int   done_cnt = 0;
  bq_t  cap2_q;
  int   done2_cnt = 0;
  logic txf_prev = 1'b0;

  always @(posedge clk) txf_prev <= tx_full;

  always @(negedge clk) begin
    if (wr_uart) begin
      cap_q.push_back(w_data);
      wcyc_q.push_back(cyc);
      check("no_wr_while_full", txf_prev, 1'b0);
    end
    if (done) done_cnt++;
    if (wr2) cap2_q.push_back(wd2);
    if (done2) done2_cnt++;
  end

  // Bench TX FIFO: 4 entries, full flag registered one cycle after a write.
  logic [7:0]  fq[$];
  int          pop_idx = 0;
  logic        fifo_full_r = 1'b0;
  logic [47:0] pat = 48'h31_41_32_46_0D_0A;
  logic [7:0]  fexp;
  logic [7:0]  fgot;

  always @(posedge clk) begin
    if (use_fifo) begin
      if (wr_uart) begin
        check("fifo_no_overflow", fq.size() < 4, 1'b1);
        if (fq.size() < 4) fq.push_back(w_data);
      end
      if (fq.size() > 0 && (drain_all || $urandom_range(3) == 0)) begin
        fexp = pat[47 - 8 * (pop_idx % 6) -: 8];
        fgot = fq.pop_front();
        check("fifo_stream", fgot, fexp);
        pop_idx++;
      end
      fifo_full_r <= (fq.size() == 4);
    end else begin
      fifo_full_r <= 1'b0;
    end
  end

  assign tx_full = use_fifo ? fifo_full_r : tx_force;

  task automatic run_msg(input logic [15:0] v, input bq_t exp, input bit timing,
                         input int hold_len, input bit inject, input bit rand_bp);
    int k, guard, busy_cycles;
    bit held;
    cap_q.delete();
    wcyc_q.delete();
    done_cnt = 0;
    value = v;
    start = 1'b1;
    k = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    busy_cycles = 0;
    held = 0;
    while (!done && guard < 600) begin
      if (busy) busy_cycles++;
      if (inject && guard == 3) begin
        start = 1'b1;
        value = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      if (hold_len > 0 && !held && cap_q.size() == 1) begin
        held = 1;
        tx_force = 1'b1;
        repeat (hold_len) begin
          @(posedge clk); #1;
          guard++;
        end
        check("hold_no_writes", cap_q.size(), 1);
        tx_force = 1'b0;
      end
      if (rand_bp) tx_force = 1'($urandom_range(1));
      @(posedge clk); #1;
      guard++;
    end
    tx_force = 1'b0;
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("busy_low_at_done", busy, 1'b0);
    if (timing) begin
      check("done_cycle", cyc, k + 2 * exp.size());
      check("busy_cycles", busy_cycles, 2 * exp.size());
      for (int i = 0; i < wcyc_q.size(); i++) check("write_cycle", wcyc_q[i], k + 1 + 2 * i);
    end
    @(posedge clk); #1;
    check("done_clears", done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt, 1);
    check("idle_not_busy", busy, 1'b0);
    cmp_q("stream", cap_q, exp);
  endtask

  task automatic run_small(input logic [7:0] v, input bq_t exp);
    int k, guard;
    cap2_q.delete();
    done2_cnt = 0;
    value2 = v;
    start2 = 1'b1;
    k = cyc + 1;
    @(posedge clk); #1;
    start2 = 1'b0;
    guard = 0;
    while (!done2 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("small_done_cycle", cyc, k + 2 * exp.size());
    check("small_busy_low", busy2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("small_done_count", done2_cnt, 1);
    cmp_q("small_stream", cap2_q, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    bq_t  q;
    logic [15:0] rv;
    int guard;

    tbl[0] = '{16'h1A2F, 48'h31_41_32_46_0D_0A};
    tbl[1] = '{16'h0000, 48'h30_30_30_30_0D_0A};
    tbl[2] = '{16'hFFFF, 48'h46_46_46_46_0D_0A};
    tbl[3] = '{16'h9C05, 48'h39_43_30_35_0D_0A};

    reset_n = 1'b0; start = 1'b0; value = 16'h0; start2 = 1'b0; value2 = 8'h0;
    tx_force = 1'b0; use_fifo = 1'b0; drain_all = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_uart", wr_uart, 1'b0);
    check("rst_w_data", w_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr2", wr2, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven messages, no backpressure, full timing checks
    for (int i = 0; i < 4; i++) begin
      q.delete();
      for (int j = 0; j < 6; j++) q.push_back(tbl[i].chars[47 - 8 * j -: 8]);
      run_msg(tbl[i].value, q, 1'b1, 0, 1'b0, 1'b0);
    end

    // Random values, timing checked
    repeat (3) begin
      rv = 16'($urandom);
      run_msg(rv, ref_msg(int'(rv), 4, 1'b1, 1'b1), 1'b1, 0, 1'b0, 1'b0);
    end

    // Random values with random tx_full toggling
    repeat (6) begin
      rv = 16'($urandom);
      run_msg(rv, ref_msg(int'(rv), 4, 1'b1, 1'b1), 1'b0, 0, 1'b0, 1'b1);
    end

    // Long backpressure hold after the first write
    run_msg(16'h0009, ref_msg(9, 4, 1'b1, 1'b1), 1'b0, 20, 1'b0, 1'b0);

    // start with a different value while busy is ignored
    run_msg(16'h1A2F, ref_msg(16'h1A2F, 4, 1'b1, 1'b1), 1'b1, 0, 1'b1, 1'b0);

    // Small configuration: lowercase, no CR LF
    q.delete();
    q.push_back(8'h62);
    q.push_back(8'h65);
    run_small(8'hBE, q);
    repeat (4) begin
      rv = 16'($urandom_range(255));
      run_small(rv[7:0], ref_msg(int'(rv), 2, 1'b0, 1'b0));
    end

    // Back-to-back messages into the bench FIFO, start on every done
    use_fifo = 1'b1;
    pop_idx = 0;
    value = 16'h1A2F;
    start = 1'b1;
    for (int m = 0; m < 5; m++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", busy, 1'b1);
      guard = 0;
      while (!done && guard < 1000) begin
        @(posedge clk); #1;
        guard++;
      end
      check("fifo_done", done, 1'b1);
      if (m < 4) start = 1'b1;
    end
    drain_all = 1'b1;
    guard = 0;
    while (fq.size() > 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("fifo_popped", pop_idx, 30);
    use_fifo = 1'b0;
    drain_all = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset after the third write
    cap_q.delete();
    value = 16'h1A2F;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (cap_q.size() < 3 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("pre_reset_writes", cap_q.size(), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_wr_uart", wr_uart, 1'b0);
    check("async_rst_w_data", w_data, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_no_writes", cap_q.size(), 3);
    check("post_reset_busy", busy, 1'b0);
    run_msg(16'h1A2F, ref_msg(16'h1A2F, 4, 1'b1, 1'b1), 1'b1, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
